pre_fetch_stage: RTL and testbench
==================================

Name: pre_fetch_stage

Overview:
Pre-IF pipeline stage, directly upstream of the fetch stage. Owns the architectural fetch PC. Issues one icache request per instruction and hands the accepted request to the fetch stage through the valid/allowin handshake. Also redirects on pipeline flush or BPU flush, buffers instruction words that return early, and flags cancelled in-flight reads.

Parameters:
RESET_PC, 32'hBFC0_0000, fetch address after reset
EXC_VECTOR, 32'hBFC0_0380, general exception entry used on non-eret flush

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
fs_allowin  in  1  fetch stage accepts a new entry this cycle
fs_to_pfs_valid  in  1  fetch stage currently holds a valid entry
fs_inst_pending  in  1  fetch stage entry still awaits its icache data_ok
fs_br_op  in  1  fetch stage instruction is a branch/jump; the PFS entry is its delay slot
bpu_flush  in  1  branch redirect request
bpu_target  in  32  branch redirect PC
pipeline_flush  in  1  exception/eret flush
pipeline_eret  in  1  qualifies pipeline_flush as eret
c0_epc  in  32  eret target
pfs_to_fs_valid  out  1  entry offered to fetch stage
pfs_pc  out  32  PC of offered entry
pfs_inst_valid  out  1  pfs_inst holds the entry's instruction
pfs_inst  out  32  buffered instruction word
pfs_ex  out  1  fetch address error on entry
pfs_exccode  out  5  5'h04 (AdEL) when pfs_ex, else 0
pfs_badvaddr  out  32  faulting PC when pfs_ex, else 0
pfs_data_cancel  out  1  a cancelled read is still outstanding; fetch stage must discard the next data_ok
icache_req  out  1  request valid
icache_addr  out  32  request address
icache_addr_ok  in  1  request accepted
icache_data_ok  in  1  read data returned, in-order
icache_rdata  in  32  read data

Behaviour:
- Reset (asynchronous, reset low). All outputs are 0 except icache_addr, which equals RESET_PC. The state machine enters S_REQ with pc = RESET_PC.
- State S_REQ:
  - If pc[1:0] == 0, drive icache_req = 1 and icache_addr = pc. On addr_ok, go to S_WAIT and set next pc = pc+4.
  - If pc[1:0] != 0, do not request. Go straight to S_HOLD with pfs_ex = 1, exccode 5'h04, badvaddr = pc.
- State S_WAIT: pfs_to_fs_valid = 1.
  - On fs_allowin, transfer the entry. The fetch stage then owns that data_ok. Return to S_REQ; a new request may be issued in the same cycle.
  - If data_ok arrives while the fetch stage has no pending read (!fs_inst_pending), the data belongs to PFS. Capture rdata into pfs_inst, set pfs_inst_valid, go to S_HOLD.
- State S_HOLD: entry complete, pfs_to_fs_valid = 1. On fs_allowin, clear pfs_inst_valid and pfs_ex, then go to S_REQ.
- data_ok ownership: data_ok always completes the oldest outstanding read. PFS claims it only in S_WAIT with !fs_inst_pending, or in S_CANCEL.
- Redirect priority: pipeline_flush > bpu_flush > sequential pc+4.
- pipeline_flush:
  - Next pc = pipeline_eret ? c0_epc : EXC_VECTOR.
  - Squash the PFS entry.
  - If the state was S_WAIT with data not yet returned, go to S_CANCEL; otherwise go to S_REQ.
- bpu_flush:
  - If fs_br_op, the PFS entry is the delay slot and is kept. Only the next pc is replaced by bpu_target, applied after the entry transfers.
  - Otherwise squash exactly as for pipeline_flush, with next pc = bpu_target.
- State S_CANCEL:
  - pfs_data_cancel = 1 and icache_req = 0.
  - The first data_ok claimed by PFS is discarded; go to S_REQ.
  - Further flushes while in S_CANCEL only update pc.
- A flush in the same cycle as addr_ok counts as an accepted request and enters S_CANCEL.
- A flush in the same cycle as a PFS-owned data_ok discards the data and enters S_REQ.
- A flush has precedence over a transfer in the same cycle: no entry is passed to the fetch stage.
- At most one read is owned by PFS at any time. pc increments mod 2^32, wrapping 32'hFFFF_FFFC to 0.
- Reset asserted mid-operation returns to reset state immediately; no cancel state is carried across reset.

Optional Feature:
PFS_STALL_CNT_EN:
- When defined, adds output pfs_stall_cnt, 32 bits.
- The counter increments on each cycle with icache_req && !icache_addr_ok, or with pfs_to_fs_valid && !fs_allowin. It saturates at 32'hFFFF_FFFF and clears on reset.
- When undefined, the port and the logic are absent; behaviour is otherwise identical.

Test Plan:
1. Release reset with addr_ok = 1 constantly and fs_allowin = 1 -> icache_addr sequence BFC00000, BFC00004, BFC00008; pfs_pc follows one entry per cycle.
2. S_WAIT with fs_allowin = 0, !fs_inst_pending, data_ok with rdata = 0x24020001 -> pfs_inst_valid = 1, pfs_inst = 0x24020001; it clears on the cycle after fs_allowin.
3. bpu_flush with fs_br_op = 1, bpu_target = 0x80001000, PFS holding pc 0x80000008 -> 0x80000008 still transfers; next icache_addr = 0x80001000.
4. pipeline_flush without eret while in S_WAIT before data_ok -> pfs_data_cancel = 1; next data_ok is dropped; next request is 0xBFC00380 with no entry offered in between.
5. Redirect to 0x80000002 -> no icache_req; pfs_ex = 1, exccode 0x04, badvaddr 0x80000002; entry transfers on fs_allowin.
6. Drive reset low while in S_CANCEL -> all outputs 0 immediately; icache_addr = BFC00000 once reset is released.

Source files
------------

// File: rtl/pre_fetch_stage.sv
// Pre-IF stage: owns the fetch PC, issues icache requests and hands entries to the fetch stage.
// Define PFS_STALL_CNT_EN to add the saturating pfs_stall_cnt output.
module pre_fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'hBFC0_0000,
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fs_allowin,
    input  logic        fs_to_pfs_valid,
    input  logic        fs_inst_pending,
    input  logic        fs_br_op,
    input  logic        bpu_flush,
    input  logic [31:0] bpu_target,
    input  logic        pipeline_flush,
    input  logic        pipeline_eret,
    input  logic [31:0] c0_epc,
    output logic        pfs_to_fs_valid,
    output logic [31:0] pfs_pc,
    output logic        pfs_inst_valid,
    output logic [31:0] pfs_inst,
    output logic        pfs_ex,
    output logic [4:0]  pfs_exccode,
    output logic [31:0] pfs_badvaddr,
    output logic        pfs_data_cancel,
`ifdef PFS_STALL_CNT_EN
    output logic [31:0] pfs_stall_cnt,
`endif
    output logic        icache_req,
    output logic [31:0] icache_addr,
    input  logic        icache_addr_ok,
    input  logic        icache_data_ok,
    input  logic [31:0] icache_rdata
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_CANCEL} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] entry_pc_q, entry_pc_d;
    logic [31:0] inst_q, inst_d;
    logic        inst_valid_q, inst_valid_d;
    logic        ex_q, ex_d;
    logic        redir_q, redir_d;
    logic [31:0] redir_pc_q, redir_pc_d;
    logic        run_q;

    logic        squash, slot_redir, aligned, pfs_owns_data, req_fire;
    logic [31:0] flush_pc, seq_pc, after_pc;

    // A delay-slot redirect keeps the entry and only retargets the PC that follows it.
    assign squash        = pipeline_flush | (bpu_flush & ~fs_br_op);
    assign slot_redir    = bpu_flush & fs_br_op & ~pipeline_flush;
    assign flush_pc      = pipeline_flush ? (pipeline_eret ? c0_epc : EXC_VECTOR) : bpu_target;
    assign aligned       = (pc_q[1:0] == 2'b00);
    assign pfs_owns_data = icache_data_ok & ~fs_inst_pending;
    assign seq_pc        = redir_q ? redir_pc_q : pc_q + 32'd4;
    assign after_pc      = slot_redir ? bpu_target : seq_pc;

    // run_q holds off the first request until the cycle after reset release.
    assign icache_req = run_q & aligned &
                        ((state_q == S_REQ) |
                         ((state_q == S_WAIT) & fs_allowin & ~pipeline_flush & ~bpu_flush));
    assign req_fire   = icache_req & icache_addr_ok;

    // NOTE: every always_comb target gets its hold value first so no latch is inferred.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        entry_pc_d   = entry_pc_q;
        inst_d       = inst_q;
        inst_valid_d = inst_valid_q;
        ex_d         = ex_q;
        redir_d      = redir_q;
        redir_pc_d   = redir_pc_q;
        case (state_q)
            S_REQ: begin
                if (squash) begin
                    pc_d    = flush_pc;
                    redir_d = 1'b0;
                    if (req_fire) state_d = S_CANCEL;
                end else if (run_q && !aligned) begin
                    state_d    = S_HOLD;
                    ex_d       = 1'b1;
                    entry_pc_d = pc_q;
                    pc_d       = after_pc;
                    redir_d    = 1'b0;
                end else if (req_fire) begin
                    state_d    = S_WAIT;
                    entry_pc_d = pc_q;
                    pc_d       = after_pc;
                    redir_d    = 1'b0;
                end else if (slot_redir) begin
                    redir_d    = 1'b1;
                    redir_pc_d = bpu_target;
                end
            end
            S_WAIT: begin
                if (squash) begin
                    pc_d    = flush_pc;
                    state_d = pfs_owns_data ? S_REQ : S_CANCEL;
                end else begin
                    if (slot_redir) pc_d = bpu_target;
                    if (fs_allowin) begin
                        if (req_fire) begin
                            entry_pc_d = pc_q;
                            pc_d       = seq_pc;
                        end else begin
                            state_d = S_REQ;
                        end
                    end else if (pfs_owns_data) begin
                        state_d      = S_HOLD;
                        inst_d       = icache_rdata;
                        inst_valid_d = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (squash) begin
                    pc_d = flush_pc;
                end else if (slot_redir) begin
                    pc_d = bpu_target;
                end
                if (squash || fs_allowin) begin
                    state_d      = S_REQ;
                    inst_valid_d = 1'b0;
                    ex_d         = 1'b0;
                end
            end
            S_CANCEL: begin
                if (pipeline_flush || bpu_flush) pc_d = flush_pc;
                if (icache_data_ok) state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            entry_pc_q   <= 32'd0;
            inst_q       <= 32'd0;
            inst_valid_q <= 1'b0;
            ex_q         <= 1'b0;
            redir_q      <= 1'b0;
            redir_pc_q   <= 32'd0;
            run_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            entry_pc_q   <= entry_pc_d;
            inst_q       <= inst_d;
            inst_valid_q <= inst_valid_d;
            ex_q         <= ex_d;
            redir_q      <= redir_d;
            redir_pc_q   <= redir_pc_d;
            run_q        <= 1'b1;
        end
    end

    assign pfs_to_fs_valid = (state_q == S_WAIT) || (state_q == S_HOLD);
    assign pfs_pc          = entry_pc_q;
    assign pfs_inst_valid  = inst_valid_q;
    assign pfs_inst        = inst_q;
    assign pfs_ex          = ex_q;
    assign pfs_exccode     = ex_q ? 5'h04 : 5'h00;
    assign pfs_badvaddr    = ex_q ? entry_pc_q : 32'd0;
    assign pfs_data_cancel = (state_q == S_CANCEL);
    assign icache_addr     = pc_q;

`ifdef PFS_STALL_CNT_EN
    logic [31:0] stall_cnt_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= 32'd0;
        end else if (((icache_req && !icache_addr_ok) || (pfs_to_fs_valid && !fs_allowin)) &&
                     (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end
    assign pfs_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pre_fetch_stage.sv
// Directed, table-driven bench for pre_fetch_stage: one vector row per clock,
// plus hand-written reset-in-cancel and PC wrap sequences.
module tb_pre_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        fs_allowin, fs_to_pfs_valid, fs_inst_pending, fs_br_op;
    logic        bpu_flush, pipeline_flush, pipeline_eret;
    logic [31:0] bpu_target, c0_epc;
    logic        pfs_to_fs_valid, pfs_inst_valid, pfs_ex, pfs_data_cancel;
    logic [31:0] pfs_pc, pfs_inst, pfs_badvaddr;
    logic [4:0]  pfs_exccode;
    logic        icache_req, icache_addr_ok, icache_data_ok;
    logic [31:0] icache_addr, icache_rdata;
`ifdef PFS_STALL_CNT_EN
    logic [31:0] pfs_stall_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pre_fetch_stage dut (
        .clk(clk), .reset(reset),
        .fs_allowin(fs_allowin), .fs_to_pfs_valid(fs_to_pfs_valid),
        .fs_inst_pending(fs_inst_pending), .fs_br_op(fs_br_op),
        .bpu_flush(bpu_flush), .bpu_target(bpu_target),
        .pipeline_flush(pipeline_flush), .pipeline_eret(pipeline_eret), .c0_epc(c0_epc),
        .pfs_to_fs_valid(pfs_to_fs_valid), .pfs_pc(pfs_pc),
        .pfs_inst_valid(pfs_inst_valid), .pfs_inst(pfs_inst),
        .pfs_ex(pfs_ex), .pfs_exccode(pfs_exccode), .pfs_badvaddr(pfs_badvaddr),
        .pfs_data_cancel(pfs_data_cancel),
`ifdef PFS_STALL_CNT_EN
        .pfs_stall_cnt(pfs_stall_cnt),
`endif
        .icache_req(icache_req), .icache_addr(icache_addr),
        .icache_addr_ok(icache_addr_ok), .icache_data_ok(icache_data_ok),
        .icache_rdata(icache_rdata)
    );

    typedef struct {
        logic        allowin, pending, br_op, bflush;
        logic [31:0] btgt;
        logic        pflush, eret;
        logic [31:0] epc;
        logic        aok, dok;
        logic [31:0] rdata;
        logic        e_valid;
        logic [31:0] e_pc;
        logic        e_iv;
        logic [31:0] e_inst;
        logic        e_ex, e_cancel, e_req;
        logic [31:0] e_addr;
    } vec_t;

    vec_t tbl [24];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        fs_allowin      = v.allowin;
        fs_to_pfs_valid = v.pending;
        fs_inst_pending = v.pending;
        fs_br_op        = v.br_op;
        bpu_flush       = v.bflush;
        bpu_target      = v.btgt;
        pipeline_flush  = v.pflush;
        pipeline_eret   = v.eret;
        c0_epc          = v.epc;
        icache_addr_ok  = v.aok;
        icache_data_ok  = v.dok;
        icache_rdata    = v.rdata;
    endtask

    // Inputs change on the falling edge; outputs are sampled 2 ns later, before the next rising edge.
    task automatic run_row(input vec_t v, input string tag);
        @(negedge clk);
        drive(v);
        #2;
        check({tag, ".valid"}, {31'd0, pfs_to_fs_valid}, {31'd0, v.e_valid});
        if (v.e_valid) check({tag, ".pc"}, pfs_pc, v.e_pc);
        check({tag, ".inst_valid"}, {31'd0, pfs_inst_valid}, {31'd0, v.e_iv});
        if (v.e_iv) check({tag, ".inst"}, pfs_inst, v.e_inst);
        check({tag, ".ex"}, {31'd0, pfs_ex}, {31'd0, v.e_ex});
        check({tag, ".exccode"}, {27'd0, pfs_exccode}, v.e_ex ? 32'h4 : 32'h0);
        check({tag, ".badvaddr"}, pfs_badvaddr, v.e_ex ? v.e_pc : 32'h0);
        check({tag, ".cancel"}, {31'd0, pfs_data_cancel}, {31'd0, v.e_cancel});
        check({tag, ".req"}, {31'd0, icache_req}, {31'd0, v.e_req});
        check({tag, ".addr"}, icache_addr, v.e_addr);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".valid"}, {31'd0, pfs_to_fs_valid}, 32'd0);
        check({tag, ".pc"}, pfs_pc, 32'd0);
        check({tag, ".inst_valid"}, {31'd0, pfs_inst_valid}, 32'd0);
        check({tag, ".inst"}, pfs_inst, 32'd0);
        check({tag, ".ex"}, {31'd0, pfs_ex}, 32'd0);
        check({tag, ".exccode"}, {27'd0, pfs_exccode}, 32'd0);
        check({tag, ".badvaddr"}, pfs_badvaddr, 32'd0);
        check({tag, ".cancel"}, {31'd0, pfs_data_cancel}, 32'd0);
        check({tag, ".req"}, {31'd0, icache_req}, 32'd0);
        check({tag, ".addr"}, icache_addr, 32'hBFC0_0000);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t idle;
        idle = '{default: 0};

        // Sequential fetch, one entry per cycle.
        tbl[0]  = '{allowin: 1, aok: 1, e_req: 1, e_addr: 32'hBFC0_0000, default: 0};
        tbl[1]  = '{allowin: 1, aok: 1, e_valid: 1, e_pc: 32'hBFC0_0000, e_req: 1, e_addr: 32'hBFC0_0004, default: 0};
        tbl[2]  = '{allowin: 1, aok: 1, e_valid: 1, e_pc: 32'hBFC0_0004, e_req: 1, e_addr: 32'hBFC0_0008, default: 0};
        // Early data is buffered, then released on allowin.
        tbl[3]  = '{dok: 1, rdata: 32'h2402_0001, e_valid: 1, e_pc: 32'hBFC0_0008, e_addr: 32'hBFC0_000C, default: 0};
        tbl[4]  = '{e_valid: 1, e_pc: 32'hBFC0_0008, e_iv: 1, e_inst: 32'h2402_0001, e_addr: 32'hBFC0_000C, default: 0};
        tbl[5]  = '{allowin: 1, e_valid: 1, e_pc: 32'hBFC0_0008, e_iv: 1, e_inst: 32'h2402_0001, e_addr: 32'hBFC0_000C, default: 0};
        tbl[6]  = '{e_req: 1, e_addr: 32'hBFC0_000C, default: 0};
        // Squashing bpu redirect from S_REQ, then delay-slot redirect that keeps the entry.
        tbl[7]  = '{bflush: 1, btgt: 32'h8000_0008, e_req: 1, e_addr: 32'hBFC0_000C, default: 0};
        tbl[8]  = '{aok: 1, e_req: 1, e_addr: 32'h8000_0008, default: 0};
        tbl[9]  = '{pending: 1, br_op: 1, bflush: 1, btgt: 32'h8000_1000, e_valid: 1, e_pc: 32'h8000_0008, e_addr: 32'h8000_000C, default: 0};
        tbl[10] = '{allowin: 1, aok: 1, pending: 1, e_valid: 1, e_pc: 32'h8000_0008, e_req: 1, e_addr: 32'h8000_1000, default: 0};
        // Exception flush beats transfer, cancels the in-flight read.
        tbl[11] = '{allowin: 1, aok: 1, pflush: 1, e_valid: 1, e_pc: 32'h8000_1000, e_addr: 32'h8000_1004, default: 0};
        tbl[12] = '{allowin: 1, aok: 1, e_cancel: 1, e_addr: 32'hBFC0_0380, default: 0};
        tbl[13] = '{allowin: 1, aok: 1, dok: 1, rdata: 32'hDEAD_BEEF, e_cancel: 1, e_addr: 32'hBFC0_0380, default: 0};
        tbl[14] = '{allowin: 1, aok: 1, e_req: 1, e_addr: 32'hBFC0_0380, default: 0};
        tbl[15] = '{e_valid: 1, e_pc: 32'hBFC0_0380, e_addr: 32'hBFC0_0384, default: 0};
        // Redirect to a misaligned PC raises AdEL.
        tbl[16] = '{bflush: 1, btgt: 32'h8000_0002, e_valid: 1, e_pc: 32'hBFC0_0380, e_addr: 32'hBFC0_0384, default: 0};
        tbl[17] = '{dok: 1, e_cancel: 1, e_addr: 32'h8000_0002, default: 0};
        tbl[18] = '{e_addr: 32'h8000_0002, default: 0};
        tbl[19] = '{e_valid: 1, e_pc: 32'h8000_0002, e_ex: 1, e_addr: 32'h8000_0006, default: 0};
        tbl[20] = '{allowin: 1, e_valid: 1, e_pc: 32'h8000_0002, e_ex: 1, e_addr: 32'h8000_0006, default: 0};
        // eret flush, then flush coinciding with addr_ok enters S_CANCEL.
        tbl[21] = '{pflush: 1, eret: 1, epc: 32'h8000_2000, e_addr: 32'h8000_0006, default: 0};
        tbl[22] = '{aok: 1, pflush: 1, eret: 1, epc: 32'h8000_3000, e_req: 1, e_addr: 32'h8000_2000, default: 0};
        tbl[23] = '{e_cancel: 1, e_addr: 32'h8000_3000, default: 0};

        drive(idle);
        reset = 1'b0;
        @(negedge clk);
        #2;
        check_reset_state("reset0");
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 24; i++) run_row(tbl[i], $sformatf("r%0d", i));

        // Reset while in S_CANCEL takes effect without a clock edge.
        @(negedge clk);
        drive(idle);
        reset = 1'b0;
        #2;
        check_reset_state("rst_cancel");
        @(negedge clk);
        reset = 1'b1;
        #2;
        check_reset_state("rst_release");

        // PC wraps from FFFF_FFFC to 0.
        run_row('{bflush: 1, btgt: 32'hFFFF_FFFC, e_req: 1, e_addr: 32'hBFC0_0000, default: 0}, "wrap0");
        run_row('{aok: 1, e_req: 1, e_addr: 32'hFFFF_FFFC, default: 0}, "wrap1");
        run_row('{e_valid: 1, e_pc: 32'hFFFF_FFFC, e_addr: 32'h0000_0000, default: 0}, "wrap2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
